relm_ps2_rx: RTL and testbench

Hardware PS/2 device-to-host receiver that replaces the software bit-banged PS/2 pop port of the ReLM DE0-CV top. It deglitches the PS/2 clock and data lines, deserialises 11-bit frames, checks start, parity and stop bits, and queues good bytes in a small FIFO. The ReLM core reads this FIFO through a standard pop port. A push port lets software inhibit the device by holding the PS/2 clock line low.

---
 rtl/relm_ps2_rx.sv | 205 ++++++++++++++++++++
 tb/tb_relm_ps2_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/relm_ps2_rx.sv
// relm_ps2_rx -- PS/2 device-to-host receiver with a show-ahead byte FIFO.
//
// Deglitches the PS/2 clock and data pins, deserialises 11-bit frames
// (start, 8 data bits LSB first, odd parity, stop), and queues good bytes.
// ReLM reads the queue through a pop port. It can inhibit the device by
// pulling the PS/2 clock line low through the inhibit port.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   ps2_clk_in     raw PS/2 clock pin level
//   ps2_dat_in     raw PS/2 data pin level
//   ps2_clk_oe     1 = drive PS/2 clock pin low (inhibit), 0 = release
//   pop_d[WD]      pop strobe; all other bits are ignored
//   pop_q          {retry=empty, 0.., overflow @16, errors @15:8, head @7:0}
//   inh_d          bit WD = write strobe, bit 0 = inhibit value
//   inh_retry      constant 0
module relm_ps2_rx #(
  parameter int WD  = 32,
  parameter int WAF = 4,
  parameter int WTO = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic        ps2_clk_oe,
  input  logic [WD:0] pop_d,
  output logic [WD:0] pop_q,
  input  logic [WD:0] inh_d,
  output logic        inh_retry
);

  localparam int DEPTH = 2 ** WAF;
  localparam logic [WTO-1:0] TO_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------------------------------------------------------- filter
  // The raw pins are asynchronous. Requiring 8 agreeing samples before the
  // filtered level changes also absorbs any metastable first sample.
  logic [7:0] clk_sr, dat_sr;
  logic       clk_filt, dat_filt, clk_prev;
  logic [7:0] clk_win, dat_win;

  assign clk_win = {clk_sr[6:0], ps2_clk_in};
  assign dat_win = {dat_sr[6:0], ps2_dat_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sr   <= '1;
      dat_sr   <= '1;
      clk_filt <= 1'b1;
      dat_filt <= 1'b1;
      clk_prev <= 1'b1;
    end else begin
      clk_sr   <= clk_win;
      dat_sr   <= dat_win;
      if (clk_win == 8'hFF)      clk_filt <= 1'b1;
      else if (clk_win == 8'h00) clk_filt <= 1'b0;
      if (dat_win == 8'hFF)      dat_filt <= 1'b1;
      else if (dat_win == 8'h00) dat_filt <= 1'b0;
      clk_prev <= clk_filt;
    end
  end

  logic fall;
  assign fall = clk_prev & ~clk_filt;

  // ----------------------------------------------------------- frame FSM
  state_t         state;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic           par_ok;
  logic [WTO-1:0] to_cnt;
  logic           inh_reg;
  logic [7:0]     err_cnt;
  logic           frame_err;
  logic           enq;

  // Frame events for this cycle. At most one error source can fire per
  // cycle: the timeout only advances in cycles without an edge.
  always_comb begin
    frame_err = 1'b0;
    enq       = 1'b0;
    if (!inh_reg) begin
      if (fall) begin
        if (state == S_IDLE) begin
          frame_err = dat_filt;
        end else if (state == S_STOP) begin
          if (dat_filt && par_ok) enq = 1'b1;
          else                    frame_err = 1'b1;
        end
      end else if (state != S_IDLE && to_cnt == TO_MAX) begin
        frame_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par_ok  <= 1'b0;
      to_cnt  <= '0;
      inh_reg <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (inh_d[WD]) inh_reg <= inh_d[0];
      if (frame_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

      if (inh_reg) begin
        // Host holds the line: drop any partial frame silently.
        state   <= S_IDLE;
        bit_cnt <= '0;
        to_cnt  <= '0;
      end else if (fall) begin
        to_cnt <= '0;
        case (state)
          S_IDLE: begin
            if (!dat_filt) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            shift   <= {dat_filt, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_ok <= ^{shift, dat_filt};
            state  <= S_STOP;
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        if (to_cnt == TO_MAX) begin
          state  <= S_IDLE;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------------ FIFO
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [7:0] mem [DEPTH];
  logic [WAF:0] wr_ptr, rd_ptr;
  logic empty, full, do_pop, do_wr, ovf;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[WAF] != rd_ptr[WAF]) &&
                  (wr_ptr[WAF-1:0] == rd_ptr[WAF-1:0]);
  assign do_pop = pop_d[WD] & ~empty;
  // A simultaneous pop frees the slot the write lands in, so no overflow.
  assign do_wr  = enq & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[WAF-1:0]] <= shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_pop)          ovf <= 1'b0;
      else if (enq && full) ovf <= 1'b1;
    end
  end

  // ------------------------------------------------------------- outputs
  logic [WD:0] pop_next;

  always_comb begin
    pop_next         = '0;
    pop_next[WD]     = empty;
    pop_next[7:0]    = empty ? 8'h00 : mem[rd_ptr[WAF-1:0]];
    pop_next[15:8]   = err_cnt;
    pop_next[16]     = ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_q     <= '0;
      pop_q[WD] <= 1'b1;
    end else begin
      pop_q <= pop_next;
    end
  end

  assign ps2_clk_oe = inh_reg;
  assign inh_retry  = 1'b0;

  // Payload bits of the port words that carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{pop_d[WD-1:0], inh_d[WD-1:1]};

endmodule

// File: tb/tb_relm_ps2_rx.sv
module tb_relm_ps2_rx;

  localparam int WD   = 32;
  localparam int WAF  = 4;
  localparam int WTO  = 14;
  localparam int HALF = 20;   // PS/2 half period in system clocks

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ps2_clk_in, ps2_dat_in, ps2_clk_oe, inh_retry;
  logic [WD:0] pop_d, pop_q, inh_d;
  logic        dev_clk, dev_dat;

  // Open-collector line: the host pulls clock low when inhibiting.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat;

  always #5 clk = ~clk;

  relm_ps2_rx #(.WD(WD), .WAF(WAF), .WTO(WTO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in), .ps2_clk_oe(ps2_clk_oe),
    .pop_d(pop_d), .pop_q(pop_q), .inh_d(inh_d), .inh_retry(inh_retry)
  );

  // Reference model: queue of accepted bytes plus status flags.
  logic [7:0] mq[$];
  int         m_err;
  bit         m_ovf;
  int         checks = 0;
  int         errors = 0;
  int         nframe = 0;

  function automatic logic [WD:0] expected();
    logic [WD:0] e;
    e = '0;
    e[WD]    = (mq.size() == 0);
    if (mq.size() != 0) e[7:0] = mq[0];
    e[15:8]  = m_err[7:0];
    e[16]    = m_ovf;
    return e;
  endfunction

  task automatic check(input string tag, input logic [WD:0] obs, input logic [WD:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check(tag, pop_q, expected());
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      dev_dat = b[i];
      wait_cyc(HALF);
      dev_clk = 1'b0;
      wait_cyc(HALF);
      dev_clk = 1'b1;
    end
    dev_dat = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    send_bits(frame(d, bad_par, bad_stop), 11);
    wait_cyc(2 * HALF);
    if (bad_par || bad_stop) begin
      if (m_err < 255) m_err++;
    end else if (mq.size() == 2 ** WAF) begin
      m_ovf = 1'b1;
    end else begin
      mq.push_back(d);
    end
    nframe++;
    $display("frame %0d data %h bad_par %0d bad_stop %0d queued %0d errs %0d",
             nframe, d, bad_par, bad_stop, mq.size(), m_err);
  endtask

  task automatic do_pop();
    pop_d = '0;
    pop_d[WD] = 1'b1;
    wait_cyc(1);
    pop_d = '0;
    wait_cyc(2);
    if (mq.size() != 0) begin
      void'(mq.pop_front());
      m_ovf = 1'b0;
    end
    $display("pop queued %0d ovf %0d", mq.size(), m_ovf);
  endtask

  task automatic wr_inh(input bit v);
    inh_d = '0;
    inh_d[WD] = 1'b1;
    inh_d[0]  = v;
    wait_cyc(1);
    inh_d = '0;
    $display("inhibit write %0d", v);
  endtask

  initial begin
    logic [WD:0] rst_val;
    rst_val = '0;
    rst_val[WD] = 1'b1;
    rst_n = 1'b0; dev_clk = 1'b1; dev_dat = 1'b1; pop_d = '0; inh_d = '0;
    m_err = 0; m_ovf = 1'b0;

    // Reset state
    wait_cyc(3);
    check("reset_pop_q", pop_q, rst_val);
    check("reset_oe", {{WD{1'b0}}, ps2_clk_oe}, '0);
    rst_n = 1'b1;
    wait_cyc(3);
    check("idle_pop_q", pop_q, rst_val);
    check("inh_retry", {{WD{1'b0}}, inh_retry}, '0);

    // Good frame then pop
    send_frame(8'h1C, 1'b0, 1'b0);
    check_model("good_1c");
    do_pop();
    check_model("good_1c_popped");

    // Parity error
    send_frame(8'h1C, 1'b1, 1'b0);
    check_model("parity_err");

    // Start error: one clock pulse with data high while idle
    send_bits(11'h7FF, 1);
    wait_cyc(2 * HALF);
    m_err++;
    $display("start-error pulse errs %0d", m_err);
    check_model("start_err");

    // Timeout: start plus 3 data bits, then silence
    send_bits(frame(8'h55, 1'b0, 1'b0), 4);
    wait_cyc(2 ** WTO + 100);
    m_err++;
    $display("timeout errs %0d", m_err);
    check_model("timeout");
    send_frame(8'hF0, 1'b0, 1'b0);
    check_model("after_timeout_f0");
    do_pop();
    check_model("after_timeout_pop");

    // Overflow with 17 frames
    for (int d = 1; d <= 17; d++) send_frame(d[7:0], 1'b0, 1'b0);
    check_model("overflow_full");
    do_pop();
    check_model("overflow_cleared");
    while (mq.size() != 0) begin
      do_pop();
      check_model("drain");
    end
    do_pop();
    check_model("pop_when_empty");

    // Inhibit mid-frame
    check("oe_before_inh", {{WD{1'b0}}, ps2_clk_oe}, '0);
    send_bits(frame(8'h33, 1'b0, 1'b0), 5);
    wr_inh(1'b1);
    check("oe_inhibited", {{WD{1'b0}}, ps2_clk_oe}, {{WD{1'b0}}, 1'b1});
    wait_cyc(100);
    check_model("inhibit_no_err");
    wr_inh(1'b0);
    check("oe_released", {{WD{1'b0}}, ps2_clk_oe}, '0);
    wait_cyc(3 * HALF);
    check_model("inhibit_released");
    send_frame(8'hAA, 1'b0, 1'b0);
    check_model("after_inhibit_aa");
    do_pop();

    // Glitches shorter than the filter window
    dev_dat = 1'b1; dev_clk = 1'b0; wait_cyc(5); dev_clk = 1'b1;
    wait_cyc(30);
    check_model("glitch_data_high");
    dev_dat = 1'b0; dev_clk = 1'b0; wait_cyc(5); dev_clk = 1'b1;
    wait_cyc(10); dev_dat = 1'b1; wait_cyc(30);
    check_model("glitch_data_low");
    send_frame(8'h3C, 1'b0, 1'b0);
    check_model("after_glitch_3c");
    do_pop();

    // Randomized frames and pops against the model
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      int kind;
      d = 8'($urandom);
      kind = $urandom_range(0, 9);
      send_frame(d, kind == 8, kind == 9);
      check_model("rand_frame");
      if ($urandom_range(0, 1) == 1) begin
        do_pop();
        check_model("rand_pop");
      end
    end

    // Asynchronous reset mid-frame with data queued
    send_frame(8'h5A, 1'b0, 1'b0);
    send_bits(frame(8'h77, 1'b0, 1'b0), 5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    mq.delete(); m_err = 0; m_ovf = 1'b0;
    $display("async reset mid-frame");
    check("async_reset", pop_q, rst_val);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(3);
    check_model("post_reset");
    send_frame(8'hC3, 1'b0, 1'b0);
    check_model("post_reset_c3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
